branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Fetch-side consumer of the branch outcome (alu_bcond) produced in EX.
- Predicts the next PC in IF using a direct-mapped BTB with 2-bit saturating counters.
- Is trained from EX with the resolved outcome.
- Flags mispredictions and supplies the corrected PC for the flush path.
- Keeps performance counters.

Parameters:
- INDEX_BITS, 5, BTB index width; entries = 2^INDEX_BITS, index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2].
- CNT_INIT, 2'b01, counter value written on reset (weakly not-taken).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- fetch_pc  input  32  PC of the instruction in IF.
- pred_taken  output  1  prediction is taken (combinational).
- pred_next_pc  output  32  predicted next PC (combinational).
- ex_valid  input  1  EX holds a resolved branch/jump this cycle (not a bubble).
- ex_pc  input  32  PC of the EX instruction.
- ex_is_jump  input  1  EX instruction is JAL/JALR (always taken).
- ex_taken  input  1  resolved direction: alu_bcond for branches, 1 for jumps.
- ex_target  input  32  resolved target address.
- ex_pred_next_pc  input  32  pred_next_pc carried down the pipeline with the EX instruction.
- mispredict  output  1  EX outcome differs from the prediction (combinational).
- correct_pc  output  32  actual next PC for the EX instruction.
- branch_count  output  32  resolved branches/jumps since reset.
- mispredict_count  output  32  mispredictions since reset.

Behaviour:
- Storage per entry:
  - valid, 1 bit.
  - tag, 32-INDEX_BITS-2 bits.
  - target, 32 bits.
  - cnt, 2 bits.
  - jmp, 1 bit.
- Reset (synchronous, at the clk edge with reset=1):
  - All valid=0, cnt=CNT_INIT, jmp=0.
  - Both counters = 0.
  - Any ex_valid in that cycle is ignored.
  - Outputs after reset: pred_taken=0, pred_next_pc=fetch_pc+4.
  - mispredict and correct_pc follow their combinational inputs.
- Prediction (0-cycle, combinational on fetch_pc):
  - hit = valid & (tag == fetch_pc tag).
  - pred_taken = hit & (jmp | cnt[1]).
  - pred_next_pc = pred_taken ? target : fetch_pc+4.
  - All arithmetic is modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
- Resolution (combinational on EX inputs):
  - actual = ex_taken ? ex_target : ex_pc+4.
  - correct_pc = actual.
  - mispredict = ex_valid & (ex_pred_next_pc != actual).
  - A taken branch predicted taken to a stale target also counts as a mispredict.
- Update (at the clk edge when ex_valid & !reset, entry selected by ex_pc index):
  - Tag hit, branch: cnt += 1 if taken (saturates at 2'b11), cnt -= 1 if not taken (saturates at 2'b00).
  - Tag hit, taken: target = ex_target.
  - Tag hit, jump: jmp=1, cnt=2'b11.
  - Tag miss or invalid, taken: allocate (overwrite) with valid=1, the new tag, target=ex_target, jmp=ex_is_jump, cnt = ex_is_jump ? 2'b11 : 2'b10.
  - Tag miss, not taken: no change.
- Counters:
  - branch_count increments when ex_valid.
  - mispredict_count increments when mispredict.
  - Both saturate at 32'hFFFFFFFF; no wrap.
- Simultaneous IF read and EX write to the same index: IF sees the pre-update entry; there is no bypass.
- Latency: a new entry is visible to fetch the cycle after the update edge.
- Aliasing: distinct PCs that share an index evict each other; the tag compare prevents false hits.
- The block does not gate on pipeline stalls. The hazard unit must hold ex_valid=0 for bubbles and flushed instructions, so each instruction updates exactly once.

Test Plan:
- Reset, then fetch_pc=0x100 -> pred_taken=0, pred_next_pc=0x104; branch_count=0.
- EX: branch at 0x100 taken to 0x80, with ex_pred_next_pc=0x104 -> mispredict=1, correct_pc=0x80. Next cycle, fetch 0x100 -> pred_taken=1, pred_next_pc=0x80 (cnt=2'b10); mispredict_count=1.
- Same branch resolved taken 3 times, then not taken once -> cnt goes 10→11→11→10; still predicts taken. A second not-taken (cnt=01) -> pred_next_pc=0x104.
- JAL at 0x200 to 0x400, then resolved repeatedly -> always predicted taken; jmp=1, cnt=11.
- Alias: 0x100 allocated, then a taken branch at 0x100+(4<<INDEX_BITS)=0x180 -> fetching 0x100 misses (pred_next_pc=0x104); fetching 0x180 hits.
- Same-cycle fetch_pc=0x100 with EX allocating 0x100 -> pred_taken=0 that cycle, 1 the next. Reset asserted with ex_valid=1 -> entry not written, counters 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters: predicts the next
// fetch PC in IF, is trained by resolved branches/jumps from EX, and counts mispredictions.
module branch_predictor #(
    parameter int         INDEX_BITS = 5,
    parameter logic [1:0] CNT_INIT   = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_next_pc,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_jump,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic [31:0] ex_pred_next_pc,
    output logic        mispredict,
    output logic [31:0] correct_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int ENTRIES = 2 ** INDEX_BITS;
    localparam int TAG_W   = 32 - INDEX_BITS - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] jmp_q, jmp_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];
    logic [1:0]         cnt_d    [ENTRIES];
    logic [31:0]        branch_count_q, branch_count_d;
    logic [31:0]        mispredict_count_q, mispredict_count_d;

    logic [INDEX_BITS-1:0] f_idx_s, e_idx_s;
    logic [TAG_W-1:0]      f_tag_s, e_tag_s;
    logic                  f_hit_s, e_hit_s;
    logic [31:0]           actual_pc_s;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        if (c == 2'b11) begin
            sat_inc = 2'b11;
        end else begin
            sat_inc = c + 2'd1;
        end
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        if (c == 2'b00) begin
            sat_dec = 2'b00;
        end else begin
            sat_dec = c - 2'd1;
        end
    endfunction

    // Fetch-side lookup; reads the pre-update entry, no bypass from EX.
    always_comb begin
        f_idx_s    = fetch_pc[INDEX_BITS+1:2];
        f_tag_s    = fetch_pc[31:INDEX_BITS+2];
        f_hit_s    = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
        pred_taken = f_hit_s && (jmp_q[f_idx_s] || cnt_q[f_idx_s][1]);
        if (pred_taken) begin
            pred_next_pc = target_q[f_idx_s];
        end else begin
            pred_next_pc = fetch_pc + 32'd4;
        end
    end

    // Resolution of the EX instruction against the PC it was fetched with.
    always_comb begin
        if (ex_taken) begin
            actual_pc_s = ex_target;
        end else begin
            actual_pc_s = ex_pc + 32'd4;
        end
        correct_pc = actual_pc_s;
        mispredict = ex_valid && (ex_pred_next_pc != actual_pc_s);
    end

    // Next-state of the BTB entry addressed by ex_pc.
    always_comb begin
        valid_d  = valid_q;
        jmp_d    = jmp_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        e_idx_s  = ex_pc[INDEX_BITS+1:2];
        e_tag_s  = ex_pc[31:INDEX_BITS+2];
        e_hit_s  = valid_q[e_idx_s] && (tag_q[e_idx_s] == e_tag_s);
        if (ex_valid) begin
            if (e_hit_s) begin
                if (ex_is_jump) begin
                    jmp_d[e_idx_s] = 1'b1;
                    cnt_d[e_idx_s] = 2'b11;
                end else if (ex_taken) begin
                    cnt_d[e_idx_s] = sat_inc(cnt_q[e_idx_s]);
                end else begin
                    cnt_d[e_idx_s] = sat_dec(cnt_q[e_idx_s]);
                end
                if (ex_taken) begin
                    target_d[e_idx_s] = ex_target;
                end else begin
                    target_d[e_idx_s] = target_q[e_idx_s];
                end
            end else if (ex_taken) begin
                // Miss or alias: overwrite the slot with the new branch.
                valid_d[e_idx_s]  = 1'b1;
                tag_d[e_idx_s]    = e_tag_s;
                target_d[e_idx_s] = ex_target;
                jmp_d[e_idx_s]    = ex_is_jump;
                if (ex_is_jump) begin
                    cnt_d[e_idx_s] = 2'b11;
                end else begin
                    cnt_d[e_idx_s] = 2'b10;
                end
            end else begin
                valid_d[e_idx_s] = valid_q[e_idx_s];
            end
        end else begin
            valid_d[e_idx_s] = valid_q[e_idx_s];
        end
    end

    // Saturating performance counters.
    always_comb begin
        if (ex_valid && (branch_count_q != 32'hFFFF_FFFF)) begin
            branch_count_d = branch_count_q + 32'd1;
        end else begin
            branch_count_d = branch_count_q;
        end
        if (mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end else begin
            mispredict_count_d = mispredict_count_q;
        end
    end

    // Control state: valid/jmp/cnt and counters, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q            <= {ENTRIES{1'b0}};
            jmp_q              <= {ENTRIES{1'b0}};
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else begin
            valid_q            <= valid_d;
            jmp_q              <= jmp_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Tag/target payload; only meaningful behind valid, so it is not reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= tag_q[i];
                target_q[i] <= target_q[i];
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
            end
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule
